// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered 8N1 UART transmitter with byte FIFO and baud counter
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int CNT_W        = 13,
    parameter int DEPTH        = 8,
    parameter int ADDR_W       = 3
) (
    input  logic              ex_clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              tx_pin,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              overflow
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam logic [ADDR_W:0]  L_DEPTH     = (ADDR_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] L_BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overflow;

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_baud;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_shift;
    logic              r_tx;

    logic              w_full;
    logic              w_empty;
    logic              w_baud_last;
    logic              w_push;
    logic              w_pop;
    logic              w_tx_next;
    logic [7:0]        w_head;

    assign w_full      = (r_count == L_DEPTH);
    assign w_empty     = (r_count == '0);
    assign w_baud_last = (r_baud == L_BAUD_LAST);
    assign w_head      = r_mem[r_rd_ptr];
    assign w_push      = wr_en && !w_full;
    // Pops happen only at a frame boundary: from IDLE or on the last stop-bit cycle.
    assign w_pop       = !w_empty && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_last));

    always_comb begin
        w_tx_next = 1'b1;
        case (r_state)
            S_START: w_tx_next = 1'b0;
            S_DATA:  w_tx_next = r_shift[0];
            default: w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge ex_clk) begin
        if (w_push && !reset) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge ex_clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            if (wr_en && w_full) begin
                r_overflow <= 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
                2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge ex_clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            // Line driven from the registered state, so it trails the state by one cycle.
            r_tx <= w_tx_next;
            case (r_state)
                S_IDLE: begin
                    r_baud <= '0;
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_baud_last) begin
                        r_baud    <= '0;
                        r_bit_idx <= '0;
                        r_state   <= S_DATA;
                    end else begin
                        r_baud <= r_baud + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_baud_last) begin
                        r_baud  <= '0;
                        r_shift <= {1'b0, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_baud <= r_baud + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (w_baud_last) begin
                        r_baud <= '0;
                        if (w_pop) begin
                            r_shift <= w_head;
                            r_state <= S_START;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign tx_pin   = r_tx;
    assign full     = w_full;
    assign empty    = w_empty;
    assign count    = r_count;
    assign busy     = (r_state != S_IDLE);
    assign overflow = r_overflow;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam int FRAME = 10 * CPB;

    logic       ex_clk;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       tx_pin;
    logic       full;
    logic       empty;
    logic [3:0] count;
    logic       busy;
    logic       overflow;

    uart_tx_fifo #(
        .CLKS_PER_BIT(CPB),
        .CNT_W(3),
        .DEPTH(DEPTH),
        .ADDR_W(3)
    ) dut (
        .ex_clk(ex_clk),
        .reset(reset),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .tx_pin(tx_pin),
        .full(full),
        .empty(empty),
        .count(count),
        .busy(busy),
        .overflow(overflow)
    );

    initial ex_clk = 1'b0;
    always #5 ex_clk = ~ex_clk;

    int checks = 0;
    int errors = 0;

    // Reference: queue of pending bytes plus a frame timer over a 10-bit frame image.
    logic [7:0] mq[$];
    logic       m_active = 1'b0;
    int         m_t      = 0;
    logic [9:0] m_frame  = 10'h3ff;
    logic       m_tx     = 1'b1;
    logic       m_ovf    = 1'b0;

    // Line decoder: recovers bytes from tx_pin, independent of the reference.
    logic [7:0] rxq[$];
    logic       rx_on   = 1'b0;
    int         rx_c    = 0;
    logic [7:0] rx_byte = 8'h00;
    int         busy_cycles = 0;

    typedef struct {
        logic [7:0] data;
        logic [9:0] line;
    } vec_t;
    vec_t vecs[5];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic step(input logic wr, input logic [7:0] d, input logic rst);
        logic pop;
        logic push;
        logic full_pre;
        logic [7:0] b;
        wr_en   = wr;
        wr_data = d;
        reset   = rst;
        @(posedge ex_clk);
        if (rst) begin
            mq.delete();
            m_active = 1'b0;
            m_t      = 0;
            m_tx     = 1'b1;
            m_ovf    = 1'b0;
            rx_on    = 1'b0;
        end else begin
            full_pre = (mq.size() == DEPTH);
            m_tx     = m_active ? m_frame[m_t / CPB] : 1'b1;
            pop      = (mq.size() > 0) && (!m_active || m_t == FRAME - 1);
            push     = wr && !full_pre;
            if (wr && full_pre) m_ovf = 1'b1;
            if (m_active && m_t != FRAME - 1) begin
                m_t++;
            end else if (pop) begin
                b        = mq.pop_front();
                m_frame  = {1'b1, b, 1'b0};
                m_active = 1'b1;
                m_t      = 0;
            end else begin
                m_active = 1'b0;
                m_t      = 0;
            end
            if (push) mq.push_back(d);
        end
        #1;
        chk("tx_pin", 32'(tx_pin), 32'(m_tx));
        chk("busy", 32'(busy), 32'(m_active));
        chk("count", 32'(count), 32'(mq.size()));
        chk("full", 32'(full), 32'(mq.size() == DEPTH));
        chk("empty", 32'(empty), 32'(mq.size() == 0));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (busy === 1'b1) busy_cycles++;
        if (!rst) begin
            if (!rx_on) begin
                if (tx_pin === 1'b0) begin
                    rx_on = 1'b1;
                    rx_c  = 0;
                end
            end else begin
                rx_c++;
                if ((rx_c % CPB) == CPB / 2 && rx_c / CPB >= 1 && rx_c / CPB <= 8)
                    rx_byte[rx_c / CPB - 1] = tx_pin;
                if (rx_c == 9 * CPB + CPB / 2) begin
                    chk("stop_bit", 32'(tx_pin), 32'd1);
                    rxq.push_back(rx_byte);
                    rx_on = 1'b0;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((m_active || mq.size() != 0) && k < 12 * FRAME) begin
            step(1'b0, 8'h00, 1'b0);
            k++;
        end
        chk(name, 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'hA5, 10'b1101001010};
        vecs[1] = '{8'h00, 10'b1000000000};
        vecs[2] = '{8'hFF, 10'b1111111110};
        vecs[3] = '{8'h3C, 10'b1001111000};
        vecs[4] = '{8'h55, 10'b1010101010};

        wr_en = 1'b0; wr_data = 8'h00; reset = 1'b1;
        repeat (3) step(1'b0, 8'h00, 1'b1);
        chk("rst_tx", 32'(tx_pin), 32'd1);
        chk("rst_empty", 32'(empty), 32'd1);
        idle(50);

        // Single frames: exact line shape and latency.
        foreach (vecs[v]) begin
            step(1'b1, vecs[v].data, 1'b0);
            chk("wr_count", 32'(count), 32'd1);
            step(1'b0, 8'h00, 1'b0);
            chk("lat_tx_high", 32'(tx_pin), 32'd1);
            chk("lat_busy", 32'(busy), 32'd1);
            for (int k = 0; k < 10; k++) begin
                for (int c = 0; c < CPB; c++) begin
                    step(1'b0, 8'h00, 1'b0);
                    chk($sformatf("line_%02h_bit%0d", vecs[v].data, k), 32'(tx_pin), 32'(vecs[v].line[k]));
                end
            end
            chk("frame_end_busy", 32'(busy), 32'd0);
            chk("frame_end_empty", 32'(empty), 32'd1);
            idle(3);
        end

        // Back-to-back frames with no gap.
        rxq.delete();
        busy_cycles = 0;
        step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'hFF, 1'b0);
        drain("b2b_drain");
        idle(2);
        chk("b2b_busy_cycles", 32'(busy_cycles), 32'(2 * FRAME));
        chk("b2b_nbytes", 32'(rxq.size()), 32'd2);
        if (rxq.size() == 2) begin
            chk("b2b_byte0", 32'(rxq[0]), 32'h00);
            chk("b2b_byte1", 32'(rxq[1]), 32'hFF);
        end

        // Nine writes fit because the first pops early; a tenth overflows.
        step(1'b0, 8'h00, 1'b1);
        rxq.delete();
        for (int i = 1; i <= 9; i++) step(1'b1, 8'(i), 1'b0);
        chk("nine_peak_count", 32'(count), 32'd8);
        chk("nine_no_ovf", 32'(overflow), 32'd0);
        step(1'b1, 8'hEE, 1'b0);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd8);
        drain("nine_drain");
        idle(2);
        chk("nine_nbytes", 32'(rxq.size()), 32'd9);
        for (int i = 0; i < rxq.size() && i < 9; i++)
            chk($sformatf("nine_byte%0d", i), 32'(rxq[i]), 32'(i + 1));

        // Reset mid-frame during data bit 3.
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h3C, 1'b0);
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h22, 1'b0);
        for (int k = 0; k < 60 && !(m_active && m_t / CPB == 4); k++) step(1'b0, 8'h00, 1'b0);
        chk("mid_queued", 32'(count), 32'd2);
        step(1'b0, 8'h00, 1'b1);
        chk("mid_rst_tx", 32'(tx_pin), 32'd1);
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        rxq.delete();
        step(1'b1, 8'h55, 1'b0);
        drain("post_rst_drain");
        idle(2);
        chk("post_rst_nbytes", 32'(rxq.size()), 32'd1);
        if (rxq.size() == 1) chk("post_rst_byte", 32'(rxq[0]), 32'h55);

        // Write on the pop cycle of a full FIFO is rejected.
        step(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
        for (int k = 0; k < 2 * FRAME && !(m_active && m_t == FRAME - 1); k++) step(1'b0, 8'h00, 1'b0);
        chk("pop_edge_full", 32'(count), 32'd8);
        chk("pop_edge_ovf0", 32'(overflow), 32'd0);
        step(1'b1, 8'h99, 1'b0);
        chk("pop_edge_count", 32'(count), 32'd7);
        chk("pop_edge_ovf1", 32'(overflow), 32'd1);
        drain("pop_edge_drain");

        // Random traffic with occasional resets.
        for (int i = 0; i < 1000; i++) begin
            step(($urandom_range(0, 2) == 0), 8'($urandom), ($urandom_range(0, 299) == 0));
        end
        drain("rand_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
